// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word accesses onto a word-wide data memory.
// Sub-word stores go through a read-modify-write of the addressed word.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Reject illegal width codes, misaligned accesses and addresses past the memory
    always_comb begin
        if (req_we) begin
            f3_bad = (req_funct3 > F_W);
        end else begin
            f3_bad = (req_funct3 == 3'd3) || (req_funct3 > F_HU);
        end
        misaligned   = ((req_funct3 == F_H || req_funct3 == F_HU) && req_addr[0])
                     || ((req_funct3 == F_W) && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err      = f3_bad || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane insertion for sub-word stores
    always_comb begin
        lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F_B:     load_val = {{24{lane_b[7]}}, lane_b};
            F_BU:    load_val = {24'h0, lane_b};
            F_H:     load_val = {{16{lane_h[15]}}, lane_h};
            F_HU:    load_val = {16'h0, lane_h};
            default: load_val = mem_rd;
        endcase
        merged = mem_rd;
        if (funct3_q == F_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == F_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LOAD: begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = load_val;
            end
            S_RMW: begin
                state_d = S_WRITE;
                merge_d = merged;
            end
            S_WRITE: begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            funct3_q     <= 3'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Memory port: request address while idle, latched address otherwise
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_a      = (state_q == S_IDLE) ? {2'b00, req_addr[31:2]} : {2'b00, addr_q[31:2]};
        mem_wd     = (funct3_q == F_W) ? wdata_q : merge_q;
        mem_we     = (state_q == S_WRITE) && we_q && !rst;
        resp_valid = resp_valid_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, random accesses and
// a streaming phase, all checked against a byte-lane reference memory model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned NW        = 64;
    localparam int unsigned NS        = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int vec_cnt = 0;
    int err_cnt = 0;
    int we_cnt  = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        poke_en = 1'b0;
    logic [31:0] poke_idx;
    logic [31:0] poke_val;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Attached data memory plus a write-pulse counter
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx[9:0]] <= poke_val;
        else if (mem_we) mem[mem_a[9:0]] <= mem_wd;
        if (mem_we) we_cnt <= we_cnt + 1;
    end
    assign mem_rd = (mem_a < 32'(MEM_WORDS)) ? mem[mem_a[9:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 32'(idx);
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: decide error, result and latency from the access rules; apply stores
    task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic err, output logic [31:0] rd,
                           output int lat);
        int          f;
        int          sh;
        logic [31:0] idx;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        f   = int'(f3);
        idx = addr >> 2;
        sh  = 8 * int'(addr % 4);
        err = (we ? (f > 2) : (f == 3 || f > 5))
            || ((f == 1 || f == 5) && (addr % 2 != 0))
            || (f == 2 && (addr % 4 != 0))
            || (idx >= 32'(MEM_WORDS));
        rd  = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            w   = ref_mem[idx];
            if (f == 2) v = w;
            else if (f == 0 || f == 4) v = (w >> sh) & 32'hFF;
            else v = (w >> sh) & 32'hFFFF;
            if (f == 0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            if (f == 1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            rd = v;
        end else begin
            lat  = (f == 2) ? 2 : 3;
            mask = (f == 0) ? 32'hFF : (f == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
            w    = ref_mem[idx];
            ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endtask

    // One isolated access: latency, response, write pulses and resulting memory word
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          lat;
        int          we_at;
        int          we0;
        int          n;
        logic [31:0] idx;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        predict(we, f3, addr, wd, e_err, e_rd, e_lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        we0        = we_cnt;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        lat   = 0;
        we_at = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) we_at = lat;
        end while (!resp_valid && lat < 8);
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        if (we && !e_err) check("we_cycle", 32'(we_at), 32'(e_lat - 1));
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("err_hold", 32'(resp_err), 32'(e_err));
        check("we_count", 32'(we_cnt - we0), (we && !e_err) ? 32'd1 : 32'd0);
        idx = addr >> 2;
        if (idx < 32'(NW)) check("mem_word", mem[idx[9:0]], ref_mem[idx[9:0]]);
    endtask

    logic        s_we   [NS];
    logic [31:0] s_addr [NS];
    logic [31:0] s_wd   [NS];
    logic [32:0] exp_q  [$];

    task automatic present(input int k);
        req_we     = s_we[k];
        req_funct3 = 3'd2;
        req_addr   = s_addr[k];
        req_wdata  = s_wd[k];
    endtask

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        logic [32:0] e;
        int          e_lat;
        int          k;
        int          we0;
        logic        acc;
        logic        rw;
        logic [2:0]  rf;
        logic [31:0] ra;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < int'(NW); i++) poke(i, $urandom);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);

        // Directed loads from a sign-bit-heavy word
        poke(28, 32'h8000_00F0);
        do_access(1'b0, 3'd0, 32'h70, 32'h0);
        check("lb_const", resp_rdata, 32'hFFFF_FFF0);
        do_access(1'b0, 3'd5, 32'h72, 32'h0);
        check("lhu_const", resp_rdata, 32'h0000_8000);
        do_access(1'b0, 3'd1, 32'h72, 32'h0);
        check("lh_const", resp_rdata, 32'hFFFF_8000);
        do_access(1'b0, 3'd4, 32'h73, 32'h0);
        do_access(1'b0, 3'd2, 32'h70, 32'h0);

        // Directed byte store with read-modify-write
        poke(5, 32'h1122_3344);
        do_access(1'b1, 3'd0, 32'h15, 32'h0000_00AB);
        check("sb_const", mem[5], 32'h1122_AB44);
        do_access(1'b1, 3'd1, 32'h16, 32'h5566_7788);

        // Directed rejects
        do_access(1'b0, 3'd2, 32'h72, 32'h0);
        do_access(1'b1, 3'd1, 32'h13, 32'h1234);
        do_access(1'b0, 3'd3, 32'h10, 32'h0);
        do_access(1'b1, 3'd4, 32'h10, 32'h0);
        do_access(1'b0, 3'd2, 32'h1000, 32'h0);
        do_access(1'b0, 3'd2, 32'h0FFC, 32'h0);

        // Reset during the write cycle of a word store
        poke(2, 32'h1234_5678);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h08;
        req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        we0 = we_cnt;
        @(negedge clk);
        check("pre_rst_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1 check("we_gated_rst", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_mem", mem[2], 32'h1234_5678);
        check("abort_we_cnt", 32'(we_cnt - we0), 32'd0);
        @(negedge clk);
        check("abort_no_valid", 32'(resp_valid), 32'd0);

        // Random accesses, including illegal codes and out-of-range addresses
        for (int i = 0; i < 150; i++) begin
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ra = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
            else ra = 32'($urandom_range(0, NW * 4 - 1));
            do_access(rw, rf, ra, $urandom);
        end

        // Streaming word accesses with req_valid held high
        for (int i = 0; i < int'(NS); i++) begin
            s_we[i]   = (i % 2 == 0);
            s_addr[i] = 32'h40 + 32'(4 * ((i / 2) % 4));
            s_wd[i]   = $urandom;
        end
        @(negedge clk);
        present(0);
        req_valid = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 400 && (k < int'(NS) || exp_q.size() > 0); cyc++) begin
            acc = 1'b0;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_err", 32'(resp_err), 32'(e[32]));
                    check("stream_rdata", resp_rdata, e[31:0]);
                end
            end
            if (k < int'(NS) && req_ready) begin
                predict(s_we[k], 3'd2, s_addr[k], s_wd[k], e_err, e_rd, e_lat);
                exp_q.push_back({e_err, e_rd});
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < int'(NS)) present(k);
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("stream_issued", 32'(k), 32'(NS));
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 16; i < 20; i++) check("stream_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
